// File: rtl/t03_mem_arbiter.sv
// t03_mem_arbiter: shares one memory bus between instruction fetch (I) and load/store (D)
module t03_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 255,
    parameter int D_PRIORITY = 0
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ack,
    output logic                i_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_sel,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                d_err,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_sel,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ack
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, DONE} state_t;

    state_t            state, state_nx;
    logic              take_d, gnt_d, last_d, err_q, bus, timeout, grant;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  cnt;

    assign bus     = (state == BUS_I) || (state == BUS_D);
    assign timeout = (TIMEOUT != 0) && (cnt == CNT_LAST);
    assign grant   = (state == IDLE) && (state_nx != IDLE);

    // arbitrate in IDLE (D wins only if alone, prioritised, or it is its turn); end bus cycle on ack or timeout
    always_comb begin
        state_nx = state;
        take_d   = d_req && (!i_req || D_PRIORITY != 0 || !last_d);
        case (state)
            IDLE:         state_nx = (i_req || d_req) ? (take_d ? BUS_D : BUS_I) : IDLE;
            BUS_I, BUS_D: state_nx = (m_ack || timeout) ? DONE : state;
            default:      state_nx = IDLE;
        endcase
    end

    // state, owner of the current transaction, round-robin history and saturating wait counter
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state  <= IDLE;
            gnt_d  <= 1'b0;
            last_d <= 1'b1;
            cnt    <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                gnt_d  <= take_d;
                last_d <= take_d;
            end
            cnt <= bus ? ((&cnt) ? cnt : cnt + 1'b1) : '0;
        end
    end

    // bus request fields, latched once per grant so requester changes cannot disturb the bus
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            m_we    <= 1'b0;
            m_sel   <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else if (grant) begin
            m_we    <= take_d && d_we;
            m_sel   <= take_d ? d_sel : '1;
            m_addr  <= take_d ? d_addr : i_addr;
            m_wdata <= take_d ? d_wdata : '0;
        end
    end

    // response captured at the end of the bus cycle; an ack in the timeout cycle still counts as success
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (bus && m_ack) begin
            rdata_q <= m_we ? '0 : m_rdata;
            err_q   <= 1'b0;
        end else if (bus && timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end
    end

    assign m_req   = bus;
    assign i_ack   = (state == DONE) && !gnt_d;
    assign d_ack   = (state == DONE) && gnt_d;
    assign i_err   = i_ack && err_q;
    assign d_err   = d_ack && err_q;
    assign i_rdata = i_ack ? rdata_q : '0;
    assign d_rdata = d_ack ? rdata_q : '0;
endmodule

// File: tb/tb_t03_mem_arbiter.sv
// tb_t03_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_t03_mem_arbiter;
    logic        clk = 1'b0, nRst = 1'b0;
    logic        i_req, d_req, d_we, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_sel;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_ack, i_err, d_ack, d_err, m_req, m_we;
    logic [3:0]  m_sel;

    logic        i_req2, d_req2, d_we2, m_ack2;
    logic [31:0] i_addr2, d_addr2, d_wdata2, m_rdata2;
    logic [3:0]  d_sel2;
    logic [31:0] i_rdata2, d_rdata2, m_addr2, m_wdata2;
    logic        i_ack2, i_err2, d_ack2, d_err2, m_req2, m_we2;
    logic [3:0]  m_sel2;

    int n_cmp = 0, n_bad = 0;

    t03_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .D_PRIORITY(0)) dut (
        .clk(clk), .nRst(nRst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_sel(m_sel), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    t03_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0), .D_PRIORITY(1)) dut_prio (
        .clk(clk), .nRst(nRst),
        .i_req(i_req2), .i_addr(i_addr2), .i_rdata(i_rdata2), .i_ack(i_ack2), .i_err(i_err2),
        .d_req(d_req2), .d_we(d_we2), .d_sel(d_sel2), .d_addr(d_addr2), .d_wdata(d_wdata2),
        .d_rdata(d_rdata2), .d_ack(d_ack2), .d_err(d_err2),
        .m_req(m_req2), .m_we(m_we2), .m_sel(m_sel2), .m_addr(m_addr2), .m_wdata(m_wdata2),
        .m_rdata(m_rdata2), .m_ack(m_ack2)
    );

    // zero-wait bus for the priority instance; read data derived from the address
    assign m_ack2   = m_req2;
    assign m_rdata2 = m_addr2 ^ 32'h5A5A_5A5A;

    always #5 clk = ~clk;

    task automatic do_reset();
        nRst = 1'b0;
        i_req = 0; d_req = 0; d_we = 0; d_sel = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
        m_ack = 0; m_rdata = 0;
        i_req2 = 0; d_req2 = 0; d_we2 = 0; d_sel2 = 0; i_addr2 = 0; d_addr2 = 0; d_wdata2 = 0;
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        nRst = 1'b0;
        i_req = 1; d_req = 1; i_addr = 32'hFFFF_FFFF; d_addr = 32'h1234_5678; m_ack = 1; m_rdata = 32'hCAFE_F00D;
        #1;
        n_cmp++;
        if ({m_req, m_we, m_sel, m_addr, m_wdata, i_ack, i_err, i_rdata, d_ack, d_err, d_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got m_req=%b m_addr=%h i_ack=%b d_ack=%b want all 0", m_req, m_addr, i_ack, d_ack);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({m_req, i_ack, d_ack, m_addr} !== '0) begin
            n_bad++;
            $display("FAIL reset_held: got m_req=%b i_ack=%b d_ack=%b m_addr=%h want 0", m_req, i_ack, d_ack, m_addr);
        end
        do_reset();
    endtask

    task automatic test_fetch();
        do_reset();
        i_req = 1; i_addr = 32'h100;
        @(negedge clk);
        n_cmp++;
        if ({m_req, m_we, m_sel, m_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
            n_bad++;
            $display("FAIL fetch_bus: got req=%b we=%b sel=%h addr=%h want 1 0 f 00000100", m_req, m_we, m_sel, m_addr);
        end
        m_ack = 1; m_rdata = 32'h0050_0093;
        @(negedge clk);
        n_cmp++;
        if ({i_ack, i_err, d_ack, m_req} !== 4'b1000 || i_rdata !== 32'h0050_0093) begin
            n_bad++;
            $display("FAIL fetch_ack: got ack=%b err=%b d_ack=%b m_req=%b rdata=%h want 1 0 0 0 00500093", i_ack, i_err, d_ack, m_req, i_rdata);
        end
        i_req = 0; m_ack = 0; m_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        n_cmp++;
        if ({i_ack, m_req} !== 2'b00) begin
            n_bad++;
            $display("FAIL fetch_after: got i_ack=%b m_req=%b want 0 0", i_ack, m_req);
        end
    endtask

    task automatic test_tie_rr();
        bit exp_d;
        do_reset();
        i_req = 1; d_req = 1; i_addr = 32'h1000; d_addr = 32'h2000; d_we = 0; d_sel = 4'hF;
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2) == 1;
            @(negedge clk);
            n_cmp++;
            if (m_req !== 1'b1 || m_addr !== (exp_d ? 32'h2000 : 32'h1000)) begin
                n_bad++;
                $display("FAIL tie_grant%0d: got m_req=%b addr=%h want 1 %h", k, m_req, m_addr, exp_d ? 32'h2000 : 32'h1000);
            end
            m_ack = 1; m_rdata = 32'h10 + k;
            @(negedge clk);
            n_cmp++;
            if ({i_ack, d_ack} !== {!exp_d, exp_d}) begin
                n_bad++;
                $display("FAIL tie_ack%0d: got i_ack=%b d_ack=%b want %b %b", k, i_ack, d_ack, !exp_d, exp_d);
            end
            m_ack = 0;
            @(negedge clk);
        end
        i_req = 0; d_req = 0;
        @(negedge clk);
    endtask

    task automatic test_d_priority();
        int dn;
        bit found;
        do_reset();
        i_req2 = 1; d_req2 = 1; i_addr2 = 32'h700; d_addr2 = 32'h800; d_we2 = 0; d_sel2 = 4'hF;
        dn = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (m_req2) begin
                n_cmp++;
                if (m_addr2 !== 32'h800) begin
                    n_bad++;
                    $display("FAIL prio_addr: got %h want 00000800", m_addr2);
                end
            end
            n_cmp++;
            if (i_ack2 !== 1'b0) begin
                n_bad++;
                $display("FAIL prio_i_ack: got %b want 0", i_ack2);
            end
            if (d_ack2) begin
                dn++;
                n_cmp++;
                if (d_rdata2 !== (32'h800 ^ 32'h5A5A_5A5A)) begin
                    n_bad++;
                    $display("FAIL prio_rdata: got %h want %h", d_rdata2, 32'h800 ^ 32'h5A5A_5A5A);
                end
            end
        end
        n_cmp++;
        if (dn != 10) begin
            n_bad++;
            $display("FAIL prio_count: got %0d want 10", dn);
        end
        d_req2 = 0;
        found = 0;
        for (int c = 0; c < 8 && !found; c++) begin
            @(negedge clk);
            if (i_ack2) begin
                found = 1;
                n_cmp++;
                if (i_rdata2 !== (32'h700 ^ 32'h5A5A_5A5A)) begin
                    n_bad++;
                    $display("FAIL prio_i_rdata: got %h want %h", i_rdata2, 32'h700 ^ 32'h5A5A_5A5A);
                end
            end
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL prio_i_served: got no i_ack within 8 cycles want i_ack");
        end
        i_req2 = 0;
        @(negedge clk);
    endtask

    task automatic test_store_wait();
        do_reset();
        d_req = 1; d_we = 1; d_sel = 4'b0011; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({m_req, m_we, m_sel, m_addr, m_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h2000, 32'hDEAD_BEEF} || d_ack !== 1'b0) begin
                n_bad++;
                $display("FAIL store_bus%0d: got req=%b we=%b sel=%h addr=%h wdata=%h d_ack=%b want 1 1 3 00002000 deadbeef 0",
                         k, m_req, m_we, m_sel, m_addr, m_wdata, d_ack);
            end
            d_addr = $urandom; d_wdata = $urandom; d_sel = $urandom; d_we = $urandom;
            m_ack = (k == 3); m_rdata = $urandom;
        end
        @(negedge clk);
        n_cmp++;
        if ({d_ack, d_err, i_ack, m_req} !== 4'b1000 || d_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL store_ack: got ack=%b err=%b i_ack=%b m_req=%b rdata=%h want 1 0 0 0 00000000", d_ack, d_err, i_ack, m_req, d_rdata);
        end
        d_req = 0; m_ack = 0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        do_reset();
        d_req = 1; d_we = 0; d_sel = 4'hF; d_addr = 32'h3000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (m_req !== 1'b1 || d_ack !== 1'b0) begin
                n_bad++;
                $display("FAIL timeout_wait%0d: got m_req=%b d_ack=%b want 1 0", k, m_req, d_ack);
            end
            m_ack = 0; m_rdata = $urandom;
        end
        @(negedge clk);
        n_cmp++;
        if ({d_ack, d_err, i_ack, i_err, m_req} !== 5'b11000 || d_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL timeout_ack: got ack=%b err=%b m_req=%b rdata=%h want 1 1 0 00000000", d_ack, d_err, m_req, d_rdata);
        end
        d_req = 0; m_ack = 1; m_rdata = 32'hFFFF_0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({m_req, i_ack, d_ack, i_err, d_err} !== 5'b0) begin
                n_bad++;
                $display("FAIL stray_ack%0d: got m_req=%b i_ack=%b d_ack=%b want 0 0 0", k, m_req, i_ack, d_ack);
            end
        end
        m_ack = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        i_req = 1; i_addr = 32'h400;
        @(negedge clk);
        n_cmp++;
        if (m_req !== 1'b1) begin
            n_bad++;
            $display("FAIL areset_pre: got m_req=%b want 1", m_req);
        end
        #2 nRst = 1'b0;
        #1;
        n_cmp++;
        if ({m_req, i_ack} !== 2'b00) begin
            n_bad++;
            $display("FAIL areset_drop: got m_req=%b i_ack=%b want 0 0", m_req, i_ack);
        end
        m_ack = 1; m_rdata = 32'h1111_2222;
        @(negedge clk);
        n_cmp++;
        if ({m_req, i_ack} !== 2'b00) begin
            n_bad++;
            $display("FAIL areset_noack: got m_req=%b i_ack=%b want 0 0", m_req, i_ack);
        end
        nRst = 1'b1; m_ack = 0;
        @(negedge clk);
        n_cmp++;
        if (m_req !== 1'b1 || m_addr !== 32'h400) begin
            n_bad++;
            $display("FAIL areset_reissue: got m_req=%b addr=%h want 1 00000400", m_req, m_addr);
        end
        m_ack = 1; m_rdata = 32'h3333_4444;
        @(negedge clk);
        n_cmp++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h3333_4444) begin
            n_bad++;
            $display("FAIL areset_ack: got i_ack=%b rdata=%h want 1 33334444", i_ack, i_rdata);
        end
        i_req = 0; m_ack = 0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_req = 1; i_addr = 32'h500;
        @(negedge clk);
        m_ack = 1; m_rdata = 32'hAAAA_0001;
        @(negedge clk);
        n_cmp++;
        if (i_ack !== 1'b1 || i_rdata !== 32'hAAAA_0001) begin
            n_bad++;
            $display("FAIL b2b_ack1: got i_ack=%b rdata=%h want 1 aaaa0001", i_ack, i_rdata);
        end
        i_addr = 32'h504; m_ack = 0;
        @(negedge clk);
        n_cmp++;
        if ({i_ack, m_req} !== 2'b00) begin
            n_bad++;
            $display("FAIL b2b_gap: got i_ack=%b m_req=%b want 0 0", i_ack, m_req);
        end
        @(negedge clk);
        n_cmp++;
        if (m_req !== 1'b1 || m_addr !== 32'h504) begin
            n_bad++;
            $display("FAIL b2b_second: got m_req=%b addr=%h want 1 00000504", m_req, m_addr);
        end
        m_ack = 1; m_rdata = 32'hAAAA_0002;
        @(negedge clk);
        n_cmp++;
        if (i_ack !== 1'b1 || i_rdata !== 32'hAAAA_0002) begin
            n_bad++;
            $display("FAIL b2b_ack2: got i_ack=%b rdata=%h want 1 aaaa0002", i_ack, i_rdata);
        end
        i_req = 0; m_ack = 0;
        @(negedge clk);
        n_cmp++;
        if (i_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_width: got i_ack=%b want 0", i_ack);
        end
    endtask

    // transaction-level model: pending flags per port, round-robin tie rule, waits vs. a 4-cycle timeout
    task automatic test_random(input int iters);
        bit          pi, pd, last_d, g_d, exp_we, exp_err, fin, from_done;
        logic [3:0]  exp_sel;
        logic [31:0] exp_addr, exp_wd, exp_rd;
        int          waits, r;
        do_reset();
        pi = 0; pd = 0; last_d = 1; from_done = 0;
        exp_err = 0; exp_rd = 0;
        for (int it = 0; it < iters; it++) begin
            r = (pi || pd) ? $urandom_range(0, 3) : $urandom_range(1, 3);
            if (r[0] && !pi) begin
                pi = 1; i_req = 1; i_addr = $urandom;
            end
            if (r[1] && !pd) begin
                pd = 1; d_req = 1; d_addr = $urandom; d_we = $urandom; d_sel = $urandom; d_wdata = $urandom;
            end
            m_ack = $urandom; m_rdata = $urandom;
            if (from_done) begin
                @(negedge clk);
                n_cmp++;
                if ({m_req, i_ack, d_ack} !== 3'b000) begin
                    n_bad++;
                    $display("FAIL rnd_idle%0d: got m_req=%b i_ack=%b d_ack=%b want 0 0 0", it, m_req, i_ack, d_ack);
                end
                m_ack = $urandom; m_rdata = $urandom;
            end
            g_d = pd && (!pi || !last_d);
            last_d = g_d;
            exp_addr = g_d ? d_addr : i_addr;
            exp_we   = g_d && d_we;
            exp_sel  = g_d ? d_sel : 4'hF;
            exp_wd   = g_d ? d_wdata : 32'h0;
            waits    = $urandom_range(0, 6);
            fin = 0;
            for (int c = 1; c <= 8 && !fin; c++) begin
                @(negedge clk);
                n_cmp++;
                if ({m_req, m_we, m_sel, m_addr, g_d ? m_wdata : 32'h0, i_ack, d_ack} !==
                    {1'b1, exp_we, exp_sel, exp_addr, exp_wd, 1'b0, 1'b0}) begin
                    n_bad++;
                    $display("FAIL rnd_bus%0d.%0d: got req=%b we=%b sel=%h addr=%h wdata=%h want 1 %b %h %h %h",
                             it, c, m_req, m_we, m_sel, m_addr, m_wdata, exp_we, exp_sel, exp_addr, exp_wd);
                end
                if (g_d) begin
                    d_addr = $urandom; d_we = $urandom; d_sel = $urandom; d_wdata = $urandom;
                end else begin
                    i_addr = $urandom;
                end
                m_rdata = $urandom;
                m_ack = (c == waits + 1);
                if (c == waits + 1) begin
                    fin = 1; exp_err = 0; exp_rd = exp_we ? 32'h0 : m_rdata;
                end else if (c == 4) begin
                    fin = 1; exp_err = 1; exp_rd = 32'h0;
                end
            end
            @(negedge clk);
            n_cmp++;
            if ({m_req, i_ack, i_err, d_ack, d_err} !== (g_d ? {3'b000, 1'b1, exp_err} : {2'b01, exp_err, 2'b00}) ||
                (g_d ? d_rdata : i_rdata) !== exp_rd) begin
                n_bad++;
                $display("FAIL rnd_done%0d: got i_ack=%b i_err=%b d_ack=%b d_err=%b rdata=%h want port_d=%b err=%b rdata=%h",
                         it, i_ack, i_err, d_ack, d_err, g_d ? d_rdata : i_rdata, g_d, exp_err, exp_rd);
            end
            if (g_d) begin
                pd = 0; d_req = 0;
            end else begin
                pi = 0; i_req = 0;
            end
            from_done = 1;
        end
        i_req = 0; d_req = 0; m_ack = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        do_reset();
        test_reset();
        test_fetch();
        test_tie_rr();
        test_d_priority();
        test_store_wait();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        test_random(200);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
